// File: rtl/prog_seq.sv
// Program sequencer: owns the PC, a req/done start handshake (IDLE/RUN/DONE),
// absolute and signed-relative jumps with stall, registered ALU flags and a saturating cycle counter.
module prog_seq #(
    parameter int unsigned D         = 12,
    parameter int unsigned OFFW      = 8,
    parameter int unsigned HALT_ADDR = 128,
    parameter int unsigned CW        = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req,
    input  logic            stall,
    input  logic            absjump_en,
    input  logic            reljump_en,
    input  logic [D-1:0]    target,
    input  logic [OFFW-1:0] offset,
    input  logic            pari,
    input  logic            zero,
    input  logic            sc_o,
    input  logic            sc_clr,
    input  logic            sc_en,
    output logic [D-1:0]    prog_ctr,
    output logic            run,
    output logic            done,
    output logic            pariQ,
    output logic            zeroQ,
    output logic            sc_q,
    output logic [CW-1:0]   cycles
);

    localparam int unsigned EW = (D > OFFW) ? D : OFFW;
    localparam logic [D-1:0]  HALT_PC = D'(HALT_ADDR);
    localparam logic [CW-1:0] CYC_MAX = {CW{1'b1}};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [D-1:0]  pc_q, pc_d;
    logic [CW-1:0] cycles_q, cycles_d;
    logic          pari_q, pari_d;
    logic          zero_q, zero_d;
    logic          sc_flag_q, sc_flag_d;
    logic          run_q, run_d;
    logic          done_q, done_d;

    logic          at_halt;
    logic [EW-1:0] off_ext;
    logic [EW-1:0] rel_sum;
    logic [D-1:0]  next_pc;

    // Candidate PC for an advance cycle; absolute jump has priority over relative.
    always_comb begin
        off_ext = EW'($signed(offset));
        rel_sum = EW'(pc_q) + off_ext;
        if (absjump_en) begin
            next_pc = target;
        end else if (reljump_en) begin
            next_pc = D'(rel_sum);
        end else begin
            next_pc = pc_q + D'(1);
        end
    end

    assign at_halt = (pc_q == HALT_PC);

    // Next-state and datapath update; halt check precedes stall and jumps.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cycles_d  = cycles_q;
        pari_d    = pari_q;
        zero_d    = zero_q;
        sc_flag_d = sc_flag_q;

        case (state_q)
            ST_IDLE: begin
                pc_d = '0;
                if (req) begin
                    state_d   = ST_RUN;
                    cycles_d  = '0;
                    pari_d    = 1'b0;
                    zero_d    = 1'b0;
                    sc_flag_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (at_halt) begin
                    state_d = ST_DONE;
                end else begin
                    if (cycles_q != CYC_MAX) begin
                        cycles_d = cycles_q + CW'(1);
                    end
                    if (!stall) begin
                        pc_d   = next_pc;
                        pari_d = pari;
                        zero_d = zero;
                        if (sc_clr) begin
                            sc_flag_d = 1'b0;
                        end else if (sc_en) begin
                            sc_flag_d = sc_o;
                        end
                    end
                end
            end
            ST_DONE: begin
                if (req) begin
                    state_d   = ST_RUN;
                    pc_d      = '0;
                    cycles_d  = '0;
                    pari_d    = 1'b0;
                    zero_d    = 1'b0;
                    sc_flag_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = '0;
            end
        endcase

        run_d  = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            cycles_q  <= '0;
            pari_q    <= 1'b0;
            zero_q    <= 1'b0;
            sc_flag_q <= 1'b0;
            run_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cycles_q  <= cycles_d;
            pari_q    <= pari_d;
            zero_q    <= zero_d;
            sc_flag_q <= sc_flag_d;
            run_q     <= run_d;
            done_q    <= done_d;
        end
    end

    assign prog_ctr = pc_q;
    assign run      = run_q;
    assign done     = done_q;
    assign pariQ    = pari_q;
    assign zeroQ    = zero_q;
    assign sc_q     = sc_flag_q;
    assign cycles   = cycles_q;

endmodule
